uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 256: clk cycles per serial bit; legal range 4 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: parity mode; 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port serial_i, input, 1: asynchronous serial line; idle high; LSB first.
REQ-008 SHALL have port ready_i, input, 1: consumer accepts the held word.
REQ-009 SHALL have port data_o, output, DATA_BITS: received word.
REQ-010 SHALL have port valid_o, output, 1: data_o and the error flags are valid.
REQ-011 SHALL have port parity_err_o, output, 1: parity mismatch for the held word; always 0 when PARITY=0.
REQ-012 SHALL have port frame_err_o, output, 1: one or more stop bits sampled low for the held word.
REQ-013 SHALL have port overrun_o, output, 1: one-cycle pulse when an unaccepted word is overwritten.
REQ-014 SHALL have port busy_o, output, 1: a frame is in progress.

Function
REQ-015 SHALL pass serial_i through a 2-flop synchroniser before any use; both flops reset to 1.
REQ-016 SHALL use states IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0.
REQ-017 SHALL run a bit timer that counts 0..CLOCKS_PER_BIT-1 in every non-IDLE state and wraps to 0 at each bit boundary.
REQ-018 SHALL sample each bit by 2-of-3 majority of the synchronised line at timer values H-1, H and H+1, where H = CLOCKS_PER_BIT/2 (integer division).
REQ-019 SHALL make each bit decision in the cycle where the timer equals H+1.
REQ-020 IDLE -> START when the synchronised line is 0; the timer SHALL be 0 in the first START cycle.
REQ-021 START SHALL go to IDLE if the start-bit majority is 1 (false start); this SHALL produce no valid_o and no error flags.
REQ-022 START SHALL go to DATA if the start-bit majority is 0.
REQ-023 DATA SHALL shift in exactly DATA_BITS bits, with the first received bit stored in data_o[0].
REQ-024 After DATA, the FSM SHALL go to PAR, or to STOP when PARITY=0.
REQ-025 PAR SHALL sample the parity bit and compare it against the XOR of the data bits: odd mode expects total ones odd; even mode expects total ones even.
REQ-026 STOP SHALL check STOP_BITS bits; any stop bit with majority 0 SHALL set frame error.
REQ-027 The FSM SHALL return to IDLE in the decision cycle of the last stop bit, not at the end of that bit.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 In the cycle after the last stop decision, data_o, parity_err_o and frame_err_o SHALL update together and valid_o SHALL go to 1.
REQ-030 valid_o SHALL hold 1, and the outputs SHALL stay stable, until a rising edge with valid_o=1 and ready_i=1; valid_o SHALL then clear.
REQ-031 If a new word completes while valid_o=1 and ready_i=0 in that cycle: the new word SHALL overwrite the old, valid_o SHALL stay 1, and overrun_o SHALL pulse for 1 cycle.
REQ-032 If a new word completes in the same cycle as a handshake: the old word SHALL count as accepted, the new word SHALL load with valid_o=1, and there SHALL be no overrun.
REQ-033 A break (line held low) SHALL yield data_o=0 with frame_err_o=1, once only; the FSM SHALL re-enter START only after the line has returned high.
REQ-034 The timer width SHALL be $clog2(CLOCKS_PER_BIT) bits, and the bit counter width $clog2(DATA_BITS+1) bits.

Reset
REQ-035 Reset assertion SHALL asynchronously force: state IDLE; timer and bit counter to 0; data_o=0; valid_o, parity_err_o, frame_err_o, overrun_o and busy_o to 0.
REQ-036 Reset in mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a fresh falling edge.

Verification (CLOCKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1 unless stated)
REQ-037 Bench SHALL send 0xA5 with parity bit 0, ready_i=1 -> data_o=0xA5, valid_o high for 1 cycle, both error flags 0.
REQ-038 Bench SHALL send 0x01 with parity bit 0 -> data_o=0x01, parity_err_o=1, frame_err_o=0.
REQ-039 Bench SHALL send 0x3C with the stop bit held low -> frame_err_o=1; the next correct frame 0x55 is received cleanly.
REQ-040 Bench SHALL drive a 4-cycle low glitch on an idle line -> busy_o pulses, no valid_o, no flags.
REQ-041 Bench SHALL send 0x11 then 0x22 with ready_i=0 -> overrun_o pulses once; data_o=0x22; after ready_i=1, valid_o clears.
REQ-042 Bench SHALL assert resetn low during the 4th data bit, then send 0x7E -> all outputs 0 during reset, then data_o=0x7E with no flags.

Source files
------------

// File: rtl/uart_rx_ext.sv
// UART receiver with majority-vote bit sampling, optional parity, 1 or 2 stop bits,
// and a single-entry output holding register with valid/ready handshake and overrun flag.
//
// state | meaning
// IDLE  | line idle; waits for a falling edge after having seen the line high
// START | start bit; a majority of 1 means a false start
// DATA  | shifting in DATA_BITS bits, LSB first
// PAR   | parity bit (skipped when PARITY=0)
// STOP  | stop bit(s); the last decision returns to IDLE and loads the output word
module uart_rx_ext #(
  parameter int CLOCKS_PER_BIT = 256,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 serial_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int H  = CLOCKS_PER_BIT / 2;

  localparam logic [TW-1:0] T_PRE  = TW'(H - 1);
  localparam logic [TW-1:0] T_MID  = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic                   sync_q1, line_s;
  logic [TW-1:0]          timer;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   samp_a, samp_b;
  logic                   armed;
  logic                   par_err_q, frm_err_q;
  logic                   maj, dec, par_bad, stop_fe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 1'b1;
      line_s  <= 1'b1;
    end else begin
      sync_q1 <= serial_i;
      line_s  <= sync_q1;
    end
  end

  // The third vote is the live synchronised line in the decision cycle.
  assign maj     = (samp_a & samp_b) | (samp_a & line_s) | (samp_b & line_s);
  assign dec     = (state != IDLE) && (timer == T_DEC);
  assign par_bad = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
  assign stop_fe = frm_err_q | ~maj;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      armed        <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      if (state != IDLE) timer <= (timer == T_LAST) ? '0 : timer + 1'b1;
      if (timer == T_PRE) samp_a <= line_s;
      if (timer == T_MID) samp_b <= line_s;

      case (state)
        IDLE: begin
          timer <= '0;
          // A break leaves the line low; only a high line re-arms the detector.
          if (line_s) armed <= 1'b1;
          if (armed && !line_s) begin
            state  <= START;
            busy_o <= 1'b1;
            armed  <= 1'b0;
          end
        end
        START: begin
          if (dec) begin
            if (maj) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              timer  <= '0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (dec) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_cnt == B_LAST) begin
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
              state     <= (PARITY == 0) ? STOP : PAR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (dec) begin
            par_err_q <= par_bad;
            state     <= STOP;
          end
        end
        STOP: begin
          if (dec) begin
            if (bit_cnt == S_LAST) begin
              state        <= IDLE;
              busy_o       <= 1'b0;
              timer        <= '0;
              bit_cnt      <= '0;
              data_o       <= shreg;
              parity_err_o <= par_err_q;
              frame_err_o  <= stop_fe;
              valid_o      <= 1'b1;
              overrun_o    <= valid_o & ~ready_i;
            end else begin
              frm_err_q <= stop_fe;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: a table of whole frames plus hand-written
// sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx_ext;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       serial_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

  uart_rx_ext #(
    .CLOCKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .serial_i(serial_i),
    .ready_i(ready_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         valid_cycles = 0;
  int         ovr_cnt = 0;
  int         busy_cycles = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;

  always @(negedge clk) begin
    if (valid_o) begin
      valid_cycles = valid_cycles + 1;
      cap_data = data_o;
      cap_pe = parity_err_o;
      cap_fe = frame_err_o;
    end
    if (overrun_o) ovr_cnt = ovr_cnt + 1;
    if (busy_o) busy_cycles = busy_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    serial_i = 1'b1;
  endtask

  task automatic idle(input int n);
    serial_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];
  int   base_v, base_o, base_b;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

    resetn = 1'b0;
    serial_i = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data_o}, 32'h0);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_flags", {29'h0, parity_err_o, frame_err_o, overrun_o}, 32'h0);
    resetn = 1'b1;
    idle(10);

    // 4-cycle glitch: START for 10 cycles, then a false-start return to IDLE
    base_v = valid_cycles;
    base_b = busy_cycles;
    serial_i = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_busy", busy_cycles - base_b, 10);
    check("glitch_valid", valid_cycles - base_v, 0);
    check("glitch_flags", {30'h0, parity_err_o, frame_err_o}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      base_v = valid_cycles;
      base_o = ovr_cnt;
      ready_i = 1'b1;
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop);
      idle(24);
      check($sformatf("v%0d_valid_cycles", i), valid_cycles - base_v, 1);
      check($sformatf("v%0d_data", i), {24'h0, cap_data}, {24'h0, vecs[i].exp_d});
      check($sformatf("v%0d_parity_err", i), {31'h0, cap_pe}, {31'h0, vecs[i].exp_pe});
      check($sformatf("v%0d_frame_err", i), {31'h0, cap_fe}, {31'h0, vecs[i].exp_fe});
      check($sformatf("v%0d_overrun", i), ovr_cnt - base_o, 0);
    end

    // break: one word of zeros with frame error, no restart while line stays low
    base_v = valid_cycles;
    serial_i = 1'b0;
    repeat (11 * CPB + 64) @(negedge clk);
    check("break_busy_parked", {31'h0, busy_o}, 32'h0);
    idle(30);
    check("break_valid_once", valid_cycles - base_v, 1);
    check("break_data", {24'h0, cap_data}, 32'h0);
    check("break_frame_err", {31'h0, cap_fe}, 32'h1);
    check("break_parity_err", {31'h0, cap_pe}, 32'h0);

    // overrun: two words without acceptance
    base_o = ovr_cnt;
    ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    idle(24);
    check("ovr_first_data", {24'h0, data_o}, 32'h11);
    check("ovr_first_valid", {31'h0, valid_o}, 32'h1);
    check("ovr_none_yet", ovr_cnt - base_o, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(24);
    check("ovr_pulse_once", ovr_cnt - base_o, 1);
    check("ovr_data", {24'h0, data_o}, 32'h22);
    check("ovr_valid_held", {31'h0, valid_o}, 32'h1);
    ready_i = 1'b1;
    @(negedge clk);
    check("ovr_valid_cleared", {31'h0, valid_o}, 32'h0);
    idle(10);

    // reset in the middle of data bit 3 of 0x7E (bit 3 is 1)
    serial_i = 1'b0;
    repeat (CPB) @(negedge clk);
    serial_i = 1'b0;
    repeat (CPB) @(negedge clk);
    serial_i = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    repeat (CPB / 2) @(negedge clk);
    check("mid_busy", {31'h0, busy_o}, 32'h1);
    resetn = 1'b0;
    #1;
    check("mrst_data", {24'h0, data_o}, 32'h0);
    check("mrst_valid_busy", {30'h0, valid_o, busy_o}, 32'h0);
    check("mrst_flags", {29'h0, parity_err_o, frame_err_o, overrun_o}, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle(40);
    check("post_rst_idle", {30'h0, valid_o, busy_o}, 32'h0);
    base_v = valid_cycles;
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(24);
    check("post_rst_valid", valid_cycles - base_v, 1);
    check("post_rst_data", {24'h0, cap_data}, 32'h7E);
    check("post_rst_flags", {30'h0, cap_pe, cap_fe}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
